gshare_dual_predictor: RTL and testbench
========================================

# gshare_dual_predictor

Parametrised dual-lane gshare direction predictor for the inst_buffer second-level prediction stage. It XOR-hashes a speculative global history register with each fetch PC to index a pattern history table of saturating counters, and registers a taken/not-taken prediction per lane. The EX stage trains the counters and repairs the history on a mispredict. A power-up sweep FSM initialises the table, so no per-entry valid bits are needed.

## Interface
- GHR_W, default 9: global history width in bits; must be ≤ IDX_W.
- IDX_W, default 9: PHT index width; depth is 2^IDX_W.
- CNT_W, default 2: counter width; must be ≥ 2.
- INIT_CNT, default 1: counter value written by the sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ready_o  out  1  init sweep complete.
- lk_valid_i  in  1  lookup request.
- lk_pc1_i, lk_pc2_i  in  32  lane PCs.
- lk_type1_i, lk_type2_i  in  2  lane types: 00 none, 01 branch, 10 ret, 11 jump.
- pred_valid_o  out  1  prediction valid.
- pred_taken1_o, pred_taken2_o  out  1  lane predictions.
- pred_idx1_o, pred_idx2_o  out  IDX_W  PHT index used; carried down the pipe to EX.
- pred_ghr1_o, pred_ghr2_o  out  GHR_W  history checkpoint for each lane; carried down the pipe to EX.
- upd_valid_i  in  1  EX resolution.
- upd_type_i  in  2  resolved type.
- upd_taken_i  in  1  actual direction.
- upd_mispredict_i  in  1  direction mispredicted; triggers recovery.
- upd_idx_i  in  IDX_W  returned index.
- upd_ghr_i  in  GHR_W  returned checkpoint.

## Operation
- FSM states:
  - INIT: write INIT_CNT at sweep address 0..2^IDX_W−1, one entry per cycle. Then go to RUN.
  - RUN: normal operation; stays here until reset.
- In INIT: ready_o=0, lookups produce no prediction, updates are dropped, GHR is held at 0.
- Index hash: idx_n = lk_pcn[IDX_W+1:2] ^ zero-extended GHR. Both lanes use the GHR value from the lookup cycle.
- Prediction for a lane = MSB of its counter when the lane type is 01; otherwise the lane predicts 0.
- Checkpoints:
  - pred_ghr1 = GHR.
  - pred_ghr2 = {GHR[GHR_W−2:0], 0} if lane 1 is a branch, else GHR.
- Speculative GHR shift on a RUN lookup:
  - Lane 1 is a branch: shift in pred1. If pred1=1, stop; lane 2 is off-path and does not shift.
  - Then, if lane 2 is a branch and was not cut off: shift in pred2.
  - Result: 0, 1 or 2 shifts per cycle.
- Update, when upd_valid_i=1, in RUN, and upd_type_i=01:
  - PHT[upd_idx_i] increments on taken, saturating at 2^CNT_W−1.
  - PHT[upd_idx_i] decrements on not-taken, saturating at 0.
  - Other types leave the PHT unchanged.
- Recovery, when upd_valid_i and upd_mispredict_i:
  - Type 01: GHR ← {upd_ghr_i[GHR_W−2:0], upd_taken_i}.
  - Other types: GHR ← upd_ghr_i.
  - Recovery overrides any same-cycle lookup shift. That lookup is still predicted, using the pre-recovery GHR.
- Update and lookup hitting different indices in the same cycle are independent.

## Timing
- Reset values:
  - ready_o=0, pred_valid_o=0.
  - pred_taken*=0, pred_idx*=0, pred_ghr*=0.
  - GHR=0, sweep address=0, state=INIT.
- Sweep takes 2^IDX_W cycles: ready_o rises on the 2^IDX_W-th rising edge after rst deasserts.
- Lookup latency is 1 cycle. All pred_* outputs are registered. pred_valid_o = registered (lk_valid_i & RUN), and it drops the cycle after a lookup gap.
- A PHT write and a GHR change both become visible to a lookup in the following cycle.
- rst asserted mid-sweep or in RUN: outputs clear immediately and the sweep restarts from address 0.

## Configuration
- GSHARE_FWD_EN defined: when an update and a lookup lane hit the same index in the same cycle, the lane predicts from the post-update counter.
- GSHARE_FWD_EN undefined: that lane predicts from the pre-update counter.

## Test plan
All scenarios use default parameters.

- Reset: hold rst 3 cycles, then release. Expect ready_o=0 for 512 cycles, then 1. First lookup at PC 0x1000 (type 01) predicts taken=0 (counter 01).
- Training at idx 0x040:
  - 2 taken updates: counter 01→11, and a matching lookup predicts 1.
  - 4 not-taken updates: counter saturates at 00, and the lookup predicts 0.
- Speculative shift from GHR=0x0FF:
  - Lane 1 branch predicted T, lane 2 branch: GHR becomes 0x1FF.
  - Lane 1 predicted NT, lane 2 predicted T: GHR becomes 0x1FD.
  - Both lanes type 10: GHR unchanged.
- Recovery: mispredict update with type 01, upd_ghr_i=0x0AA, taken=1, plus a same-cycle lookup. Expect GHR=0x155, the lookup shift discarded, and pred_valid_o=1 next cycle.
- Forwarding: idx 0x010 holds counter 01; a taken update and a lookup hit it in the same cycle. Expect pred_taken=1 with GSHARE_FWD_EN, 0 without.
- Reset mid-operation at sweep address 200 and again in RUN. Expect outputs 0 and ready_o low for another full 512 cycles.

Source files
------------

// File: rtl/gshare_dual_predictor.sv
// Dual-lane gshare direction predictor: GHR-hashed PHT of saturating counters,
// speculative history update, EX-driven training and recovery. Optional macro: GSHARE_FWD_EN.
module gshare_dual_predictor #(
  parameter int GHR_W    = 9,
  parameter int IDX_W    = 9,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_o,
  input  logic             lk_valid_i,
  input  logic [31:0]      lk_pc1_i,
  input  logic [31:0]      lk_pc2_i,
  input  logic [1:0]       lk_type1_i,
  input  logic [1:0]       lk_type2_i,
  output logic             pred_valid_o,
  output logic             pred_taken1_o,
  output logic             pred_taken2_o,
  output logic [IDX_W-1:0] pred_idx1_o,
  output logic [IDX_W-1:0] pred_idx2_o,
  output logic [GHR_W-1:0] pred_ghr1_o,
  output logic [GHR_W-1:0] pred_ghr2_o,
  input  logic             upd_valid_i,
  input  logic [1:0]       upd_type_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [GHR_W-1:0] upd_ghr_i
);

  localparam int               DEPTH       = 1 << IDX_W;
  localparam logic [0:0]       ST_INIT     = 1'b0;
  localparam logic [0:0]       ST_RUN      = 1'b1;
  localparam logic [1:0]       TYPE_BRANCH = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_INIT    = CNT_W'(INIT_CNT);
  localparam logic [IDX_W-1:0] SWEEP_LAST  = IDX_W'(DEPTH - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_addr;
  logic [GHR_W-1:0] ghr;
  logic [CNT_W-1:0] pht [DEPTH];

  logic             run;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx1, idx2;
  logic [CNT_W-1:0] cnt1, cnt2;
  logic             br1, br2, pred1, pred2;
  logic             upd_pht;
  logic [CNT_W-1:0] upd_old, upd_new;
  logic [GHR_W-1:0] ghr_spec, ghr_ckpt2, ghr_next;
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [CNT_W-1:0] pht_wdata;
  logic             pc_unused;

  assign run     = (state == ST_RUN);
  assign ready_o = run;

  // Both lanes hash with the history as it stands in the lookup cycle.
  assign ghr_ext = IDX_W'(ghr);
  assign idx1    = lk_pc1_i[IDX_W+1:2] ^ ghr_ext;
  assign idx2    = lk_pc2_i[IDX_W+1:2] ^ ghr_ext;

  assign pc_unused = ^{lk_pc1_i[31:IDX_W+2], lk_pc1_i[1:0],
                       lk_pc2_i[31:IDX_W+2], lk_pc2_i[1:0]};

  assign upd_pht = run & upd_valid_i & (upd_type_i == TYPE_BRANCH);
  assign upd_old = pht[upd_idx_i];

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    upd_new = upd_old;
    if (upd_taken_i) begin
      if (upd_old != CNT_MAX) upd_new = upd_old + CNT_W'(1);
    end else begin
      if (upd_old != '0) upd_new = upd_old - CNT_W'(1);
    end
  end

`ifdef GSHARE_FWD_EN
  // A same-cycle update to the looked-up entry is bypassed into the prediction.
  assign cnt1 = (upd_pht && (upd_idx_i == idx1)) ? upd_new : pht[idx1];
  assign cnt2 = (upd_pht && (upd_idx_i == idx2)) ? upd_new : pht[idx2];
`else
  assign cnt1 = pht[idx1];
  assign cnt2 = pht[idx2];
`endif

  assign br1   = (lk_type1_i == TYPE_BRANCH);
  assign br2   = (lk_type2_i == TYPE_BRANCH);
  assign pred1 = br1 & cnt1[CNT_W-1];
  assign pred2 = br2 & cnt2[CNT_W-1];

  // A predicted-taken lane 1 redirects fetch, so lane 2 never enters the history.
  always_comb begin
    ghr_spec = ghr;
    if (br1) ghr_spec = {ghr_spec[GHR_W-2:0], pred1};
    if (br2 && !(br1 && pred1)) ghr_spec = {ghr_spec[GHR_W-2:0], pred2};
  end

  assign ghr_ckpt2 = br1 ? {ghr[GHR_W-2:0], 1'b0} : ghr;

  always_comb begin
    ghr_next = ghr;
    if (run) begin
      if (upd_valid_i && upd_mispredict_i) begin
        if (upd_type_i == TYPE_BRANCH) ghr_next = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
        else                           ghr_next = upd_ghr_i;
      end else if (lk_valid_i) begin
        ghr_next = ghr_spec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      sweep_addr    <= '0;
      ghr           <= '0;
      pred_valid_o  <= 1'b0;
      pred_taken1_o <= 1'b0;
      pred_taken2_o <= 1'b0;
      pred_idx1_o   <= '0;
      pred_idx2_o   <= '0;
      pred_ghr1_o   <= '0;
      pred_ghr2_o   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_addr <= sweep_addr + IDX_W'(1);
          if (sweep_addr == SWEEP_LAST) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
      ghr          <= ghr_next;
      pred_valid_o <= lk_valid_i & run;
      if (lk_valid_i && run) begin
        pred_taken1_o <= pred1;
        pred_taken2_o <= pred2;
        pred_idx1_o   <= idx1;
        pred_idx2_o   <= idx2;
        pred_ghr1_o   <= ghr;
        pred_ghr2_o   <= ghr_ckpt2;
      end
    end
  end

  // Single write port: the sweep owns it during INIT, EX training afterwards.
  assign pht_we    = run ? upd_pht : 1'b1;
  assign pht_waddr = run ? upd_idx_i : sweep_addr;
  assign pht_wdata = run ? upd_new : CNT_INIT;

  // NOTE: the table is deliberately not reset; the power-up sweep initialises every entry.
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
  end

endmodule

// File: tb/tb_gshare_dual_predictor.sv
// Directed self-checking bench for gshare_dual_predictor (default parameters).
// Build with +define+GSHARE_FWD_EN to check the forwarding variant.
module tb_gshare_dual_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_o;
  logic        lk_valid_i = 1'b0;
  logic [31:0] lk_pc1_i = '0, lk_pc2_i = '0;
  logic [1:0]  lk_type1_i = '0, lk_type2_i = '0;
  logic        pred_valid_o, pred_taken1_o, pred_taken2_o;
  logic [8:0]  pred_idx1_o, pred_idx2_o, pred_ghr1_o, pred_ghr2_o;
  logic        upd_valid_i = 1'b0;
  logic [1:0]  upd_type_i = '0;
  logic        upd_taken_i = 1'b0, upd_mispredict_i = 1'b0;
  logic [8:0]  upd_idx_i = '0, upd_ghr_i = '0;

  int passed = 0;
  int total  = 0;

  gshare_dual_predictor dut (
    .clk(clk), .rst(rst), .ready_o(ready_o),
    .lk_valid_i(lk_valid_i), .lk_pc1_i(lk_pc1_i), .lk_pc2_i(lk_pc2_i),
    .lk_type1_i(lk_type1_i), .lk_type2_i(lk_type2_i),
    .pred_valid_o(pred_valid_o), .pred_taken1_o(pred_taken1_o), .pred_taken2_o(pred_taken2_o),
    .pred_idx1_o(pred_idx1_o), .pred_idx2_o(pred_idx2_o),
    .pred_ghr1_o(pred_ghr1_o), .pred_ghr2_o(pred_ghr2_o),
    .upd_valid_i(upd_valid_i), .upd_type_i(upd_type_i), .upd_taken_i(upd_taken_i),
    .upd_mispredict_i(upd_mispredict_i), .upd_idx_i(upd_idx_i), .upd_ghr_i(upd_ghr_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    lk_valid_i = 1'b0; lk_pc1_i = '0; lk_pc2_i = '0; lk_type1_i = '0; lk_type2_i = '0;
    upd_valid_i = 1'b0; upd_type_i = '0; upd_taken_i = 1'b0; upd_mispredict_i = 1'b0;
    upd_idx_i = '0; upd_ghr_i = '0;
  endtask

  task automatic lookup(input logic [31:0] pc1, input logic [1:0] t1,
                        input logic [31:0] pc2, input logic [1:0] t2);
    lk_valid_i = 1'b1; lk_pc1_i = pc1; lk_type1_i = t1; lk_pc2_i = pc2; lk_type2_i = t2;
    tick();
    clear_inputs();
  endtask

  task automatic train(input logic [8:0] idx, input logic taken);
    upd_valid_i = 1'b1; upd_type_i = 2'b01; upd_taken_i = taken; upd_idx_i = idx;
    tick();
    clear_inputs();
  endtask

  // A mispredicted jump loads the history verbatim without touching the table.
  task automatic set_ghr(input logic [8:0] g);
    upd_valid_i = 1'b1; upd_type_i = 2'b11; upd_mispredict_i = 1'b1; upd_ghr_i = g;
    tick();
    clear_inputs();
  endtask

  task automatic probe_ghr(output logic [8:0] g);
    lk_valid_i = 1'b1;
    tick();
    g = pred_ghr1_o;
    clear_inputs();
  endtask

  task automatic wait_sweep(input string tag);
    repeat (511) tick();
    total++; if (ready_o !== 1'b0) $display("FAIL %s_ready_early: got %b exp 0", tag, ready_o); else passed++;
    total++; if (pred_valid_o !== 1'b0) $display("FAIL %s_valid_in_init: got %b exp 0", tag, pred_valid_o); else passed++;
    clear_inputs();
    tick();
    total++; if (ready_o !== 1'b1) $display("FAIL %s_ready_rise: got %b exp 1", tag, ready_o); else passed++;
  endtask

  task automatic test_reset;
    logic [8:0] g;
    clear_inputs();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({ready_o, pred_valid_o, pred_taken1_o, pred_taken2_o, pred_idx1_o, pred_idx2_o, pred_ghr1_o, pred_ghr2_o} !== 40'd0)
      $display("FAIL reset_outputs: got rdy=%b v=%b idx1=%h ghr1=%h exp all 0", ready_o, pred_valid_o, pred_idx1_o, pred_ghr1_o);
    else passed++;
    rst = 1'b0;
    // Lookups and updates during the sweep must be ignored.
    lk_valid_i = 1'b1; lk_pc1_i = 32'h100; lk_type1_i = 2'b01;
    upd_valid_i = 1'b1; upd_type_i = 2'b01; upd_taken_i = 1'b1; upd_mispredict_i = 1'b1;
    upd_idx_i = 9'h000; upd_ghr_i = 9'h1FF;
    wait_sweep("init");
    lookup(32'h1000, 2'b01, 32'h0, 2'b00);
    total++; if (pred_valid_o !== 1'b1) $display("FAIL first_valid: got %b exp 1", pred_valid_o); else passed++;
    total++; if (pred_taken1_o !== 1'b0) $display("FAIL first_taken: got %b exp 0", pred_taken1_o); else passed++;
    total++; if (pred_idx1_o !== 9'h000) $display("FAIL first_idx: got %h exp 000", pred_idx1_o); else passed++;
    total++; if (pred_ghr1_o !== 9'h000) $display("FAIL first_ghr: got %h exp 000", pred_ghr1_o); else passed++;
    tick();
    total++; if (pred_valid_o !== 1'b0) $display("FAIL valid_drop: got %b exp 0", pred_valid_o); else passed++;
    probe_ghr(g);
    total++; if (g !== 9'h000) $display("FAIL init_ghr_held: got %h exp 000", g); else passed++;
  endtask

  task automatic test_training;
    train(9'h040, 1'b1); train(9'h040, 1'b1);
    set_ghr(9'h000);
    lookup(32'h100, 2'b01, 32'h0, 2'b00);
    total++; if (pred_taken1_o !== 1'b1) $display("FAIL train_up: got %b exp 1", pred_taken1_o); else passed++;
    total++; if (pred_idx1_o !== 9'h040) $display("FAIL train_idx: got %h exp 040", pred_idx1_o); else passed++;
    train(9'h040, 1'b1);
    set_ghr(9'h000);
    lookup(32'h100, 2'b01, 32'h0, 2'b00);
    total++; if (pred_taken1_o !== 1'b1) $display("FAIL train_sat_hi: got %b exp 1", pred_taken1_o); else passed++;
    for (int i = 0; i < 4; i++) train(9'h040, 1'b0);
    set_ghr(9'h000);
    lookup(32'h100, 2'b01, 32'h0, 2'b00);
    total++; if (pred_taken1_o !== 1'b0) $display("FAIL train_sat_lo: got %b exp 0", pred_taken1_o); else passed++;
  endtask

  task automatic test_spec_shift;
    logic [8:0] g;
    train(9'h020, 1'b1); train(9'h020, 1'b1);
    // Lane 1 taken: lane 2 is cut off.
    set_ghr(9'h0FF);
    lookup(32'h37C, 2'b01, 32'h380, 2'b01);
    total++; if ({pred_taken1_o, pred_taken2_o} !== 2'b10) $display("FAIL shift_t_preds: got %b exp 10", {pred_taken1_o, pred_taken2_o}); else passed++;
    total++; if ({pred_idx1_o, pred_idx2_o} !== {9'h020, 9'h01F}) $display("FAIL shift_t_idx: got %h/%h exp 020/01f", pred_idx1_o, pred_idx2_o); else passed++;
    total++; if ({pred_ghr1_o, pred_ghr2_o} !== {9'h0FF, 9'h1FE}) $display("FAIL shift_t_ckpt: got %h/%h exp 0ff/1fe", pred_ghr1_o, pred_ghr2_o); else passed++;
    probe_ghr(g);
    total++; if (g !== 9'h1FF) $display("FAIL shift_t_ghr: got %h exp 1ff", g); else passed++;
    // Lane 1 not taken, lane 2 taken: two shifts.
    set_ghr(9'h0FF);
    lookup(32'h0, 2'b01, 32'h37C, 2'b01);
    total++; if ({pred_taken1_o, pred_taken2_o} !== 2'b01) $display("FAIL shift_nt_preds: got %b exp 01", {pred_taken1_o, pred_taken2_o}); else passed++;
    total++; if (pred_ghr2_o !== 9'h1FE) $display("FAIL shift_nt_ckpt2: got %h exp 1fe", pred_ghr2_o); else passed++;
    probe_ghr(g);
    total++; if (g !== 9'h1FD) $display("FAIL shift_nt_ghr: got %h exp 1fd", g); else passed++;
    // Returns do not predict or shift, even on a strongly taken entry.
    set_ghr(9'h0FF);
    lookup(32'h37C, 2'b10, 32'h37C, 2'b10);
    total++; if ({pred_taken1_o, pred_taken2_o} !== 2'b00) $display("FAIL shift_ret_preds: got %b exp 00", {pred_taken1_o, pred_taken2_o}); else passed++;
    total++; if (pred_ghr2_o !== 9'h0FF) $display("FAIL shift_ret_ckpt2: got %h exp 0ff", pred_ghr2_o); else passed++;
    probe_ghr(g);
    total++; if (g !== 9'h0FF) $display("FAIL shift_ret_ghr: got %h exp 0ff", g); else passed++;
  endtask

  task automatic test_recovery;
    logic [8:0] g;
    set_ghr(9'h000);
    lk_valid_i = 1'b1; lk_pc1_i = 32'h80; lk_type1_i = 2'b01;
    upd_valid_i = 1'b1; upd_type_i = 2'b01; upd_taken_i = 1'b1; upd_mispredict_i = 1'b1;
    upd_idx_i = 9'h1AB; upd_ghr_i = 9'h0AA;
    tick();
    clear_inputs();
    total++; if (pred_valid_o !== 1'b1) $display("FAIL recov_valid: got %b exp 1", pred_valid_o); else passed++;
    total++; if ({pred_taken1_o, pred_idx1_o, pred_ghr1_o} !== {1'b1, 9'h020, 9'h000})
      $display("FAIL recov_lookup: got t=%b idx=%h ghr=%h exp t=1 idx=020 ghr=000", pred_taken1_o, pred_idx1_o, pred_ghr1_o);
    else passed++;
    probe_ghr(g);
    total++; if (g !== 9'h155) $display("FAIL recov_ghr: got %h exp 155", g); else passed++;
  endtask

  task automatic test_forwarding;
    logic exp_fwd;
`ifdef GSHARE_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    set_ghr(9'h000);
    lk_valid_i = 1'b1; lk_pc1_i = 32'h40; lk_type1_i = 2'b01;
    upd_valid_i = 1'b1; upd_type_i = 2'b01; upd_taken_i = 1'b1; upd_idx_i = 9'h010;
    tick();
    clear_inputs();
    total++; if (pred_taken1_o !== exp_fwd) $display("FAIL fwd_same_cycle: got %b exp %b", pred_taken1_o, exp_fwd); else passed++;
    set_ghr(9'h000);
    lookup(32'h40, 2'b01, 32'h0, 2'b00);
    total++; if (pred_taken1_o !== 1'b1) $display("FAIL fwd_after: got %b exp 1", pred_taken1_o); else passed++;
  endtask

  task automatic test_back_to_back;
    set_ghr(9'h000);
    lk_valid_i = 1'b1; lk_pc1_i = 32'h80; lk_type1_i = 2'b01;
    tick();
    lk_pc1_i = 32'h84;
    tick();
    clear_inputs();
    total++; if ({pred_valid_o, pred_taken1_o, pred_idx1_o, pred_ghr1_o} !== {1'b1, 1'b1, 9'h020, 9'h001})
      $display("FAIL b2b_second: got v=%b t=%b idx=%h ghr=%h exp v=1 t=1 idx=020 ghr=001", pred_valid_o, pred_taken1_o, pred_idx1_o, pred_ghr1_o);
    else passed++;
  endtask

  task automatic test_reset_mid;
    set_ghr(9'h000);
    lk_valid_i = 1'b1; lk_pc1_i = 32'h80; lk_type1_i = 2'b01;
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ready_o, pred_valid_o, pred_taken1_o, pred_taken2_o, pred_idx1_o, pred_idx2_o, pred_ghr1_o, pred_ghr2_o} !== 40'd0)
      $display("FAIL run_reset_clear: got rdy=%b v=%b t=%b idx1=%h exp all 0", ready_o, pred_valid_o, pred_taken1_o, pred_idx1_o);
    else passed++;
    clear_inputs();
    tick();
    rst = 1'b0;
    repeat (200) tick();
    #2 rst = 1'b1;
    #1;
    total++; if ({ready_o, pred_valid_o} !== 2'b00) $display("FAIL sweep_reset_clear: got %b exp 00", {ready_o, pred_valid_o}); else passed++;
    tick();
    rst = 1'b0;
    wait_sweep("resweep");
    lookup(32'h80, 2'b01, 32'h0, 2'b00);
    total++; if ({pred_taken1_o, pred_idx1_o, pred_ghr1_o} !== {1'b0, 9'h020, 9'h000})
      $display("FAIL resweep_table: got t=%b idx=%h ghr=%h exp t=0 idx=020 ghr=000", pred_taken1_o, pred_idx1_o, pred_ghr1_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_training();
    test_spec_shift();
    test_recovery();
    test_forwarding();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
